// File: rtl/insulin_dose_controller.sv
// Glucose-path decision stage: averages glycemic index samples over a fixed window,
// then either runs a timed insulin pump pulse with lockout or raises a sticky low alarm.
module insulin_dose_controller #(
  parameter int unsigned WINDOW          = 4,
  parameter int unsigned HIGH_TH         = 9,
  parameter int unsigned LOW_TH          = 3,
  parameter int unsigned DOSE_CYCLES     = 8,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sampleValid,
  input  logic [3:0] glycemicIndex,
  input  logic       alarmAck,
  output logic       sampleReady,
  output logic [3:0] averageIndex,
  output logic       avgValid,
  output logic       pumpOn,
  output logic       alarmLow,
  output logic [7:0] doseCount,
  output logic [7:0] droppedCount
);

  localparam int unsigned LOG_W = $clog2(WINDOW);
  localparam int unsigned SUM_W = 4 + LOG_W;
  localparam int unsigned CNT_W = LOG_W;
  localparam int unsigned TMR_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] DOSE_LOAD = TMR_W'(DOSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]       HIGH_AVG  = 4'(HIGH_TH);
  localparam logic [3:0]       LOW_AVG   = 4'(LOW_TH);
  localparam logic [7:0]       SAT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DOSE  = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [SUM_W-1:0]   sum, sum_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [3:0]         avg_n;
  logic               avg_valid_n;
  logic               ready_n;
  logic               pump_n;
  logic               alarm_n;
  logic [7:0]         dose_n;
  logic [7:0]         drop_n;

  logic [SUM_W-1:0]   win_sum_c;
  logic [3:0]         win_avg_c;
  logic               accept_c;
  logic               win_done_c;

  // Window arithmetic; the accumulator width guarantees no overflow for a full window.
  always_comb begin
    win_sum_c  = sum + SUM_W'(glycemicIndex);
    win_avg_c  = 4'(win_sum_c >> LOG_W);
    accept_c   = (state == ACCUM) && sampleValid;
    win_done_c = accept_c && (cnt == CNT_LAST);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    sum_n       = sum;
    cnt_n       = cnt;
    timer_n     = timer;
    avg_n       = averageIndex;
    avg_valid_n = 1'b0;
    alarm_n     = alarmLow & ~alarmAck;
    dose_n      = doseCount;
    drop_n      = droppedCount;

    if (sampleValid && (state != ACCUM) && (droppedCount != SAT_MAX)) begin
      drop_n = droppedCount + 8'd1;
    end

    case (state)
      ACCUM: begin
        if (win_done_c) begin
          sum_n       = '0;
          cnt_n       = '0;
          avg_n       = win_avg_c;
          avg_valid_n = 1'b1;
          if (win_avg_c >= HIGH_AVG) begin
            state_n = DOSE;
            timer_n = DOSE_LOAD;
          end else if (win_avg_c <= LOW_AVG) begin
            alarm_n = 1'b1;
          end
        end else if (accept_c) begin
          sum_n = win_sum_c;
          cnt_n = CNT_W'(cnt + 1'b1);
        end
      end
      DOSE: begin
        if (timer == '0) begin
          state_n = COOL;
          timer_n = COOL_LOAD;
          if (doseCount != SAT_MAX) begin
            dose_n = doseCount + 8'd1;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      COOL: begin
        if (timer == '0) begin
          state_n = ACCUM;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = ACCUM;
        timer_n = '0;
        sum_n   = '0;
        cnt_n   = '0;
      end
    endcase

    // Ready and pump are registered copies of the state being entered.
    ready_n = (state_n == ACCUM);
    pump_n  = (state_n == DOSE);
  end

  // State and output registers; reset drops the pump without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      sum          <= '0;
      cnt          <= '0;
      timer        <= '0;
      sampleReady  <= 1'b1;
      averageIndex <= '0;
      avgValid     <= 1'b0;
      pumpOn       <= 1'b0;
      alarmLow     <= 1'b0;
      doseCount    <= '0;
      droppedCount <= '0;
    end else begin
      state        <= state_n;
      sum          <= sum_n;
      cnt          <= cnt_n;
      timer        <= timer_n;
      sampleReady  <= ready_n;
      averageIndex <= avg_n;
      avgValid     <= avg_valid_n;
      pumpOn       <= pump_n;
      alarmLow     <= alarm_n;
      doseCount    <= dose_n;
      droppedCount <= drop_n;
    end
  end

endmodule

// File: tb/tb_insulin_dose_controller.sv
// Directed bench for insulin_dose_controller: dose, alarm, drop, async reset and saturation cases.
module tb_insulin_dose_controller;

  logic       clk;
  logic       rst_n;
  logic       sampleValid;
  logic [3:0] glycemicIndex;
  logic       alarmAck;
  logic       sampleReady;
  logic [3:0] averageIndex;
  logic       avgValid;
  logic       pumpOn;
  logic       alarmLow;
  logic [7:0] doseCount;
  logic [7:0] droppedCount;

  int n_cmp = 0;
  int n_bad = 0;

  insulin_dose_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sampleValid  (sampleValid),
    .glycemicIndex(glycemicIndex),
    .alarmAck     (alarmAck),
    .sampleReady  (sampleReady),
    .averageIndex (averageIndex),
    .avgValid     (avgValid),
    .pumpOn       (pumpOn),
    .alarmLow     (alarmLow),
    .doseCount    (doseCount),
    .droppedCount (droppedCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Four back-to-back samples; returns at the negedge after the final accepting edge.
  task automatic send_window(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
    @(negedge clk); sampleValid = 1'b1; glycemicIndex = a;
    @(negedge clk); glycemicIndex = b;
    @(negedge clk); glycemicIndex = c;
    @(negedge clk); glycemicIndex = d;
    @(negedge clk); sampleValid = 1'b0;
  endtask

  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 64; i++) begin
      if (pumpOn) hi++;
      else if (!sampleReady) lo++;
      else break;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!sampleReady && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sampleReady), 1);
  endtask

  initial begin
    int hi, lo, bad_windows;
    rst_n = 1'b0; sampleValid = 1'b0; glycemicIndex = 4'd0; alarmAck = 1'b0;
    #12;
    check("rst_ready", 32'(sampleReady), 1);
    check("rst_outputs", 32'({averageIndex, avgValid, pumpOn, alarmLow}), 0);
    check("rst_counts", 32'({doseCount, droppedCount}), 0);
    @(negedge clk); rst_n = 1'b1;

    // High window: 41 >> 2 = 10 -> dose
    send_window(4'd10, 4'd10, 4'd10, 4'd11);
    check("dose_avg", 32'(averageIndex), 10);
    check("dose_avgvalid", 32'(avgValid), 1);
    check("dose_ready_low", 32'(sampleReady), 0);
    measure(hi, lo);
    check("dose_pump_cycles", 32'(hi), 8);
    check("dose_cool_cycles", 32'(lo), 16);
    check("dose_ready_back", 32'(sampleReady), 1);
    check("dose_count1", 32'(doseCount), 1);

    // Low window: 11 >> 2 = 2 -> alarm
    send_window(4'd2, 4'd3, 4'd3, 4'd3);
    check("low_avg", 32'(averageIndex), 2);
    check("low_alarm", 32'(alarmLow), 1);
    check("low_pump", 32'(pumpOn), 0);
    @(negedge clk);
    @(negedge clk); alarmAck = 1'b1;
    @(negedge clk); alarmAck = 1'b0;
    check("ack_clears", 32'(alarmLow), 0);
    @(negedge clk); alarmAck = 1'b1;
    @(negedge clk); alarmAck = 1'b0;
    check("ack_when_clear", 32'(alarmLow), 0);

    // Set wins over ack on the same edge
    send_window(4'd1, 4'd1, 4'd1, 4'd1);
    check("low2_alarm", 32'(alarmLow), 1);
    @(negedge clk); sampleValid = 1'b1; glycemicIndex = 4'd0;
    @(negedge clk); glycemicIndex = 4'd0;
    @(negedge clk); glycemicIndex = 4'd0;
    @(negedge clk); glycemicIndex = 4'd4; alarmAck = 1'b1;
    @(negedge clk); sampleValid = 1'b0; alarmAck = 1'b0;
    check("setwins_avg", 32'(averageIndex), 1);
    check("setwins_alarm", 32'(alarmLow), 1);
    @(negedge clk); alarmAck = 1'b1;
    @(negedge clk); alarmAck = 1'b0;
    check("ack_clears2", 32'(alarmLow), 0);

    // Mid window with gaps: 22 >> 2 = 5, no action
    @(negedge clk); sampleValid = 1'b1; glycemicIndex = 4'd5;
    @(negedge clk); sampleValid = 1'b0;
    @(negedge clk); check("gap_ready1", 32'(sampleReady), 1);
    sampleValid = 1'b1; glycemicIndex = 4'd6;
    @(negedge clk); sampleValid = 1'b0;
    @(negedge clk);
    @(negedge clk); check("gap_avgvalid_idle", 32'(avgValid), 0);
    sampleValid = 1'b1; glycemicIndex = 4'd5;
    @(negedge clk); glycemicIndex = 4'd6;
    @(negedge clk); sampleValid = 1'b0;
    check("mid_avg", 32'(averageIndex), 5);
    check("mid_avgvalid", 32'(avgValid), 1);
    check("mid_flags", 32'({pumpOn, alarmLow, sampleReady}), 1);
    @(negedge clk);
    check("mid_avgvalid_pulse", 32'(avgValid), 0);

    // Dose with samples offered during DOSE
    send_window(4'd10, 4'd10, 4'd10, 4'd11);
    check("drop_pump", 32'(pumpOn), 1);
    sampleValid = 1'b1; glycemicIndex = 4'd15;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); sampleValid = 1'b0;
    check("drop_count", 32'(droppedCount), 3);
    wait_ready("drop_wait_ready");
    send_window(4'd4, 4'd4, 4'd5, 4'd5);
    check("drop_next_avg", 32'(averageIndex), 4);
    check("drop_next_flags", 32'({pumpOn, alarmLow}), 0);
    check("drop_dose_count", 32'(doseCount), 2);

    // Async reset during the 4th pump cycle
    send_window(4'd10, 4'd10, 4'd10, 4'd11);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_pump_before", 32'(pumpOn), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pump_async", 32'(pumpOn), 0);
    check("rst_mid_outputs", 32'({averageIndex, avgValid, alarmLow, sampleReady}), 1);
    check("rst_mid_counts", 32'({doseCount, droppedCount}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(sampleReady), 1);

    // Partial window discarded by reset
    sampleValid = 1'b1; glycemicIndex = 4'd15;
    @(negedge clk);
    @(negedge clk); sampleValid = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    send_window(4'd4, 4'd4, 4'd4, 4'd4);
    check("partial_avg", 32'(averageIndex), 4);
    check("partial_pump", 32'(pumpOn), 0);

    // 300 high windows: dose count saturates, pump timing unchanged
    bad_windows = 0;
    for (int w = 0; w < 300; w++) begin
      send_window(4'd10, 4'd10, 4'd10, 4'd10);
      measure(hi, lo);
      if (hi != 8 || lo != 16 || !sampleReady) bad_windows++;
      if (w == 254) check("sat_count_255", 32'(doseCount), 255);
    end
    check("sat_pump_timing", 32'(bad_windows), 0);
    check("sat_count_final", 32'(doseCount), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/insulin_dose_controller.md
# insulin_dose_controller

Sequential decision stage downstream of the glycemic index calculator. It accepts a stream of 4-bit glycemic index samples and averages them over a fixed window. Based on the averaged index, it either drives a timed insulin pump pulse followed by a lockout period, or raises a sticky low-glucose alarm. It is the first clocked block in the glucose path and the only one that drives actuator and alarm outputs.

## Interface
- WINDOW, 4: samples per averaging window; power of two, 2..16.
- HIGH_TH, 9: average at or above this value triggers a dose; must exceed LOW_TH.
- LOW_TH, 3: average at or below this value sets alarmLow.
- DOSE_CYCLES, 8: clock cycles pumpOn stays high per dose; range 1..255.
- COOLDOWN_CYCLES, 16: lockout cycles after a dose; range 1..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sampleValid  input  1  glycemicIndex is valid this cycle.
- glycemicIndex  input  4  unsigned index from the calculator; full 0..15 range accepted.
- alarmAck  input  1  clears alarmLow.
- sampleReady  output  1  block accepts samples (state ACCUM).
- averageIndex  output  4  last computed window average.
- avgValid  output  1  one-cycle pulse when averageIndex updates.
- pumpOn  output  1  insulin pump drive.
- alarmLow  output  1  sticky low-glucose alarm.
- doseCount  output  8  completed doses, saturating at 255.
- droppedCount  output  8  samples offered while not ready, saturating at 255.

## Operation
- States: ACCUM, DOSE, COOL. Reset state is ACCUM.
- ACCUM
  - A sample is accepted when sampleValid=1.
  - The accumulator is 4+log2(WINDOW) bits wide and has no overflow.
  - sampleCnt counts 0..WINDOW-1.
- Window completion: on the edge accepting the WINDOW-th sample:
  - avg = (sum + glycemicIndex) >> log2(WINDOW), truncating.
  - avg is registered into averageIndex, and avgValid pulses.
  - sum and sampleCnt are cleared.
  - The decision is taken on the same edge:
    - avg >= HIGH_TH: go to DOSE, load timer with DOSE_CYCLES-1.
    - avg <= LOW_TH: set alarmLow, stay in ACCUM.
    - Otherwise: stay in ACCUM, no action.
- DOSE
  - pumpOn=1 (registered, equal to state==DOSE).
  - The timer decrements each cycle; at 0, go to COOL, load timer with COOLDOWN_CYCLES-1, and increment doseCount (saturating).
- COOL
  - pumpOn=0.
  - At timer 0, return to ACCUM with sum and sampleCnt already clear.
- sampleReady=1 only in ACCUM.
  - sampleValid while not ready drops the sample and increments droppedCount (saturating).
  - A dropped sample does not enter any window.
- alarmLow
  - Set and clear operate in every state.
  - If the set condition and alarmAck occur on the same edge, set wins.
  - alarmAck with the alarm already clear has no effect.
- Partial windows persist indefinitely while sampleValid is low; there is no timeout.

## Timing
- Reset values:
  - state = ACCUM; sum, sampleCnt and timer = 0.
  - sampleReady = 1.
  - averageIndex, avgValid, pumpOn, alarmLow, doseCount and droppedCount = 0.
- Reset is asynchronous. Asserting rst_n mid-dose drops pumpOn immediately, without waiting for a clock edge, and discards any partial window.
- Latency: averageIndex, avgValid and pumpOn/alarmLow change in the cycle after the clock edge that accepted the final sample of a window.
- pumpOn is high for exactly DOSE_CYCLES consecutive cycles.
- The next sample can be accepted DOSE_CYCLES+COOLDOWN_CYCLES cycles after that edge.
- doseCount updates on the edge that leaves DOSE.
- Back-to-back valid samples are accepted every cycle in ACCUM; there are no bubbles at window boundaries.

## Test plan
- Reset, then samples 10,10,10,11 on consecutive cycles:
  - averageIndex=10 and avgValid pulses.
  - pumpOn is high for 8 cycles, then low for 16 with sampleReady=0.
  - doseCount=1.
- Samples 2,3,3,3:
  - averageIndex=2 and alarmLow=1, with pumpOn staying 0.
  - alarmAck on a later cycle makes alarmLow=0 on the next cycle.
  - A low window completing on the same edge as alarmAck leaves alarmLow=1.
- Samples 5,6,5,6 with sampleValid gaps between them: averageIndex=5, no pump, no alarm, sampleReady stays 1.
- Dose case as above with sampleValid=1 for 3 cycles during DOSE: droppedCount=3, and the next window uses only samples accepted after the return to ACCUM.
- Assert rst_n low in the 4th pumpOn cycle:
  - pumpOn falls with no clock edge.
  - All outputs read reset values, sampleReady=1 after release.
  - A 2-sample partial window is discarded.
- Drive 300 high windows: doseCount saturates at 255, pump behaviour is unchanged.
